// File: rtl/fft_feeder_pkg.sv
// -----------------------------------------------------------------------------
// fft_feeder_pkg
// Shared types and helpers for the FFT frame feeder.
//   FFT_SINK_W  : width of one Avalon-ST beat toward the FFT sink port
//   SAMPLE_W    : audio sample width
//   fft_sink_t  : beat layout {re, im, fftpts, inverse}
//   feeder_state_e : read-side FSM states
// Optional feature macro used by the feeder: FFT_FEEDER_WINDOW_EN
// -----------------------------------------------------------------------------
package fft_feeder_pkg;

  localparam int FFT_SINK_W = 43;
  localparam int SAMPLE_W   = 16;
  localparam int FFTPTS_W   = 10;

  // The real-part field is called "re" because "real" is a reserved word.
  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
    logic [FFTPTS_W-1:0] fftpts;
    logic                inverse;
  } fft_sink_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feeder_state_e;

  function automatic fft_sink_t make_beat(input logic [SAMPLE_W-1:0] sample,
                                          input int                  points);
    fft_sink_t beat;
    beat.re      = sample;
    beat.im      = '0;
    beat.fftpts  = FFTPTS_W'(points);
    beat.inverse = 1'b0;
    return beat;
  endfunction

  // Q1.15 product back to a 16-bit sample: round half up, then saturate.
  function automatic logic [SAMPLE_W-1:0] sat_round_q15(input logic signed [33:0] prod);
    logic signed [33:0] rnd;
    rnd = (prod + 34'sd16384) >>> 15;
    if (rnd > 34'sd32767) begin
      return 16'h7FFF;
    end else if (rnd < -34'sd32768) begin
      return 16'h8000;
    end else begin
      return rnd[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fft_window_rom.sv
// -----------------------------------------------------------------------------
// fft_window_rom
// Combinational Hann window table, w[k] = 0.5*(1-cos(2*pi*k/N)) in unsigned
// Q1.15, rounded to nearest and saturated to 0x7FFF (w[N/2] would be 1.0).
// Only instantiated when FFT_FEEDER_WINDOW_EN is defined.
// Ports:
//   i_idx  : sample index within the frame
//   o_coef : window coefficient for that index
// -----------------------------------------------------------------------------
module fft_window_rom #(
  parameter int N_POINTS = 256
) (
  input  logic [$clog2(N_POINTS)-1:0] i_idx,
  output logic [15:0]                 o_coef
);

  localparam real PI = 3.14159265358979323846;

  logic [15:0] w_table [0:N_POINTS-1];

  // Table contents are computed at elaboration time from N_POINTS.
  for (genvar k = 0; k < N_POINTS; k++) begin : g_coef
    localparam real WIN   = 0.5 * (1.0 - $cos(2.0 * PI * k / N_POINTS));
    localparam int  RAW_Q = $rtoi(WIN * 32768.0 + 0.5);
    localparam int  COEF  = (RAW_Q > 32767) ? 32767 : RAW_Q;
    assign w_table[k] = 16'(COEF);
  end

  assign o_coef = w_table[i_idx];

endmodule

// File: rtl/fft_frame_feeder.sv
// -----------------------------------------------------------------------------
// fft_frame_feeder
// Frames signed 16-bit audio samples into N_POINTS-beat Avalon-ST packets for
// the FFT sink. Two ping-pong banks let one frame stream while the next fills;
// samples that arrive while both banks are full are dropped and counted.
// Optional feature: define FFT_FEEDER_WINDOW_EN to apply a Hann window on the
// write path (output latency unchanged).
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_sample_valid   : one-cycle strobe per ADC sample
//   i_sample         : signed sample
//   o_valid, i_ready : Avalon-ST handshake, ready latency 0
//   o_sop, o_eop     : packet delimiters
//   o_error          : always 2'b00
//   o_data           : {re, im=0, fftpts=N_POINTS, inverse=0}
//   o_drop           : pulse per discarded sample (cycle after the strobe)
//   o_drop_cnt       : saturating dropped-sample count
// -----------------------------------------------------------------------------
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int N_POINTS   = 256,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sample_valid,
  input  logic [SAMPLE_W-1:0]   i_sample,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [1:0]            o_error,
  output logic [FFT_SINK_W-1:0] o_data,
  output logic                  o_drop,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam int               IDX_W    = $clog2(N_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = '0;

  // Both banks live in one array addressed by {bank, index}.
  logic [SAMPLE_W-1:0]   r_mem [0:2*N_POINTS-1];
  logic [1:0]            r_full;
  logic                  r_wrBank;
  logic [IDX_W-1:0]      r_wrIdx;
  logic                  r_drop;
  logic [DROP_CNT_W-1:0] r_dropCnt;

  feeder_state_e         r_state;
  logic                  r_rdBank;
  logic [IDX_W-1:0]      r_rdIdx;
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;
  fft_sink_t             r_data;

  logic                  w_wrEn;
  logic                  w_dropEn;
  logic                  w_wrLast;
  logic                  w_xfer;
  logic                  w_eopXfer;
  logic [1:0]            w_fullNext;
  logic                  w_otherBank;
  logic [IDX_W-1:0]      w_rdIdxNext;
  logic [SAMPLE_W-1:0]   w_storeData;

  // The write bank is only FULL when both banks are full.
  assign w_wrEn      = i_sample_valid & ~r_full[r_wrBank];
  assign w_dropEn    = i_sample_valid &  r_full[r_wrBank];
  assign w_wrLast    = w_wrEn & (r_wrIdx == LAST_IDX);
  assign w_xfer      = r_valid & i_ready;
  assign w_eopXfer   = w_xfer & r_eop;
  assign w_otherBank = ~r_rdBank;
  assign w_rdIdxNext = r_rdIdx + IDX_W'(1);

  // A fill and a drain always target different banks, so both can land in
  // the same cycle. The reader looks at this next-state view so a bank that
  // fills during the eop transfer starts streaming without a gap.
  always_comb begin
    w_fullNext = r_full;
    if (w_wrLast) begin
      w_fullNext[r_wrBank] = 1'b1;
    end
    if (w_eopXfer) begin
      w_fullNext[r_rdBank] = 1'b0;
    end
  end

`ifdef FFT_FEEDER_WINDOW_EN
  logic [SAMPLE_W-1:0] w_coef;
  logic signed [33:0]  w_sampleExt;
  logic signed [33:0]  w_coefExt;
  logic signed [33:0]  w_prod;

  fft_window_rom #(
    .N_POINTS (N_POINTS)
  ) u_window_rom (
    .i_idx  (r_wrIdx),
    .o_coef (w_coef)
  );

  // Coefficient is unsigned Q1.15, so it is zero-extended before the signed
  // multiply.
  assign w_sampleExt = {{18{i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_coefExt   = {18'd0, w_coef};
  assign w_prod      = w_sampleExt * w_coefExt;
  assign w_storeData = sat_round_q15(w_prod);
`else
  assign w_storeData = i_sample;
`endif

  // Sample storage carries no reset; bank validity lives in r_full.
  always_ff @(posedge i_clk) begin
    if (w_wrEn) begin
      r_mem[{r_wrBank, r_wrIdx}] <= w_storeData;
    end
  end

  // Write side: bank status, write pointer/index and drop accounting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full    <= 2'b00;
      r_wrBank  <= 1'b0;
      r_wrIdx   <= '0;
      r_drop    <= 1'b0;
      r_dropCnt <= '0;
    end else begin
      r_full <= w_fullNext;
      r_drop <= w_dropEn;
      if (w_wrEn) begin
        if (w_wrLast) begin
          r_wrIdx  <= '0;
          r_wrBank <= ~r_wrBank;
        end else begin
          r_wrIdx <= r_wrIdx + IDX_W'(1);
        end
      end
      if (w_dropEn && (r_dropCnt != {DROP_CNT_W{1'b1}})) begin
        r_dropCnt <= r_dropCnt + DROP_CNT_W'(1);
      end
    end
  end

  // Read FSM. The beat registers always hold the beat being offered; the
  // next beat is fetched only when the current one is accepted, so data,
  // sop and eop stay still through stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rdBank <= 1'b0;
      r_rdIdx  <= '0;
      r_valid  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_full[r_rdBank]) begin
            r_state <= STREAM;
            r_rdIdx <= '0;
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
            r_data  <= make_beat(r_mem[{r_rdBank, ZERO_IDX}], N_POINTS);
          end
        end
        STREAM: begin
          if (w_xfer) begin
            if (r_eop) begin
              r_rdBank <= w_otherBank;
              r_rdIdx  <= '0;
              if (w_fullNext[w_otherBank]) begin
                r_sop  <= 1'b1;
                r_eop  <= 1'b0;
                r_data <= make_beat(r_mem[{w_otherBank, ZERO_IDX}], N_POINTS);
              end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
                r_data  <= '0;
              end
            end else begin
              r_rdIdx <= w_rdIdxNext;
              r_sop   <= 1'b0;
              r_eop   <= (w_rdIdxNext == LAST_IDX);
              r_data  <= make_beat(r_mem[{r_rdBank, w_rdIdxNext}], N_POINTS);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_sop   <= 1'b0;
          r_eop   <= 1'b0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign o_valid    = r_valid;
  assign o_sop      = r_sop;
  assign o_eop      = r_eop;
  assign o_error    = 2'b00;
  assign o_data     = r_data;
  assign o_drop     = r_drop;
  assign o_drop_cnt = r_dropCnt;

endmodule
